// File: rtl/uart_pkg.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART constants, FSM encoding and baud divisor helper.
// Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Receiver FSM encoding
  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_start = 3'd1;
  localparam logic [2:0] c_st_data  = 3'd2;
  localparam logic [2:0] c_st_stop  = 3'd3;
  localparam logic [2:0] c_st_break = 3'd4;

  localparam int c_oversample = 16;
  localparam int c_data_bits  = 8;

  // Tick positions inside one bit: mid start bit and mid of every later bit
  localparam logic [3:0] c_half_tick = 4'd7;
  localparam logic [3:0] c_last_tick = 4'd15;

  // Clocks per oversample tick, truncated; shared with the transmit baud path
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / (baud * c_oversample);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module : uart_rx_if
// Brief  : Serial line plus received-byte outputs of the UART receiver.
// Rev    : 1.0  initial release
// ============================================================================
interface uart_rx_if;
  import uart_pkg::*;

  logic                   uart_rxd;
  logic [c_data_bits-1:0] rx_data;
  logic                   rx_valid;
  logic                   frame_err;
  logic                   rx_busy;

  // Receiver side
  modport master (
    input  uart_rxd,
    output rx_data,
    output rx_valid,
    output frame_err,
    output rx_busy
  );

  // Line driver / byte consumer side
  modport slave (
    output uart_rxd,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  rx_busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module : uart_baud_tick
// Brief  : Divide-by-DIV tick generator with synchronous clear.
// Rev    : 1.0  initial release
// ============================================================================
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_clr,
  output logic      o_tick
);

  localparam int             c_w    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_w-1:0] c_last = c_w'(DIV - 1);

  logic [c_w-1:0] r_cnt;

  if (DIV < 1) begin : g_bad_div
    $error("uart_baud_tick: DIV must be at least 1");
  end

  assign o_tick = (r_cnt == c_last) && !i_clr;

  // Free-running divider; clear holds phase at zero until released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == c_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module : uart_rx
// Brief  : 8N1 UART receiver, 16x oversampled, glitch-rejecting start bit,
//          one-cycle valid strobe and framing-error strobe.
// Rev    : 1.0  initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  wire logic  CLK100MHZ,
  input  wire logic  rst_n,
  uart_rx_if.master  bus
);

  localparam int c_div = calc_div(CLK_FREQ, BAUD);

  if (OVERSAMPLE != c_oversample) begin : g_bad_oversample
    $error("uart_rx: OVERSAMPLE must be 16");
  end

  logic [1:0]             r_sync;
  logic                   w_rxd_s;
  logic                   w_tick;
  logic                   w_clr;
  logic [2:0]             r_state;
  logic [3:0]             r_tcnt;
  logic [2:0]             r_bit_idx;
  logic [c_data_bits-1:0] r_shift;
  logic [c_data_bits-1:0] r_rx_data;
  logic                   r_rx_valid;
  logic                   r_frame_err;
  logic                   r_rx_busy;

  assign w_rxd_s = r_sync[1];
  // Holding the divider in clear while idle aligns tick phase to the start edge
  assign w_clr   = (r_state == c_st_idle);

  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.rx_busy   = r_rx_busy;

  uart_baud_tick #(
    .DIV (c_div)
  ) u_tick (
    .clk    (CLK100MHZ),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  // Two-flop synchronizer for the asynchronous line, idling high
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], bus.uart_rxd};
    end
  end

  // Frame FSM: start validation, mid-bit data sampling, stop check, break wait
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_idle;
      r_tcnt      <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_rx_busy   <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (!w_rxd_s) begin
            r_state   <= c_st_start;
            r_tcnt    <= '0;
            r_bit_idx <= '0;
            r_rx_busy <= 1'b1;
          end
        end
        c_st_start: begin
          if (w_tick) begin
            if (r_tcnt == c_half_tick) begin
              r_tcnt <= '0;
              if (w_rxd_s) begin
                // Line back high by mid start bit: treat as a glitch
                r_state   <= c_st_idle;
                r_rx_busy <= 1'b0;
              end else begin
                r_state <= c_st_data;
              end
            end else begin
              r_tcnt <= r_tcnt + 4'd1;
            end
          end
        end
        c_st_data: begin
          if (w_tick) begin
            if (r_tcnt == c_last_tick) begin
              r_tcnt  <= '0;
              r_shift <= {w_rxd_s, r_shift[c_data_bits-1:1]};
              if (r_bit_idx == 3'd7) begin
                r_state <= c_st_stop;
              end else begin
                r_bit_idx <= r_bit_idx + 3'd1;
              end
            end else begin
              r_tcnt <= r_tcnt + 4'd1;
            end
          end
        end
        c_st_stop: begin
          if (w_tick) begin
            if (r_tcnt == c_last_tick) begin
              r_tcnt <= '0;
              if (w_rxd_s) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
                r_rx_busy  <= 1'b0;
                r_state    <= c_st_idle;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= c_st_break;
              end
            end else begin
              r_tcnt <= r_tcnt + 4'd1;
            end
          end
        end
        c_st_break: begin
          // A held-low line reports one framing error, then waits for idle
          if (w_rxd_s) begin
            r_state   <= c_st_idle;
            r_rx_busy <= 1'b0;
          end
        end
        default: begin
          r_state   <= c_st_idle;
          r_rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module : tb_uart_rx
// Brief  : Scoreboard bench for uart_rx: a serial-line driver queues the byte
//          or framing error each frame should produce; a monitor checks them.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  // 100 MHz clock, 781250 baud -> exactly 8 clocks per tick, 128 per bit
  localparam int  c_clk_freq = 100_000_000;
  localparam int  c_baud     = 781_250;
  localparam real c_bit_ns   = 1280.0;
  // Two sync cycles plus 9.5 bit times, with one tick plus a little slack
  localparam real c_lat_ns   = 20.0 + 9.5 * c_bit_ns;
  localparam real c_lat_tol  = 120.0;

  typedef struct {
    bit           err;
    logic [7:0]   data;
    realtime      t0;
    bit           lat;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t q[$];
  exp_t e_mon;
  logic [7:0] last_good;
  int n_tests;
  int n_fail;

  uart_rx_if u_if ();

  uart_rx #(
    .CLK_FREQ   (c_clk_freq),
    .BAUD       (c_baud),
    .OVERSAMPLE (16)
  ) u_dut (
    .CLK100MHZ (clk),
    .rst_n     (rst_n),
    .bus       (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one 8N1 frame; the expected result is queued as the frame begins
  task automatic send_frame(input logic [7:0] d, input bit stop, input real bit_ns,
                            input bit lat, input real low_hold_ns);
    exp_t e;
    e.err  = !stop;
    e.data = d;
    e.t0   = $realtime;
    e.lat  = lat;
    q.push_back(e);
    u_if.uart_rxd = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      u_if.uart_rxd = d[i];
      #(bit_ns);
    end
    u_if.uart_rxd = stop;
    #(bit_ns);
    if (!stop && low_hold_ns > 0.0) #(low_hold_ns);
    u_if.uart_rxd = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    #(c_bit_ns * n);
  endtask

  // Monitor: every output strobe must match the head of the expectation queue
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      last_good = 8'h00;
    end else if (u_if.rx_valid === 1'b1 || u_if.frame_err === 1'b1) begin
      chk("valid_err_exclusive", {31'd0, u_if.rx_valid & u_if.frame_err}, 32'd0);
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: valid=%0b err=%0b data=%02h, expected no event",
                 u_if.rx_valid, u_if.frame_err, u_if.rx_data);
      end else begin
        e_mon = q.pop_front();
        if (e_mon.err) begin
          chk("frame_err_kind", {31'd0, u_if.frame_err}, 32'd1);
          chk("data_held_on_err", {24'd0, u_if.rx_data}, {24'd0, last_good});
        end else begin
          chk("rx_valid_kind", {31'd0, u_if.rx_valid}, 32'd1);
          chk("rx_data", {24'd0, u_if.rx_data}, {24'd0, e_mon.data});
          chk("busy_low_at_valid", {31'd0, u_if.rx_busy}, 32'd0);
          last_good = e_mon.data;
          if (e_mon.lat) begin
            n_tests++;
            if (($realtime - e_mon.t0) < c_lat_ns - c_lat_tol ||
                ($realtime - e_mon.t0) > c_lat_ns + c_lat_tol) begin
              n_fail++;
              $display("FAIL latency: got %0.1f ns expected %0.1f +/- %0.1f ns",
                       $realtime - e_mon.t0, c_lat_ns, c_lat_tol);
            end
          end
        end
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    last_good = 8'h00;
    u_if.uart_rxd = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_rx_data", {24'd0, u_if.rx_data}, 32'd0);
    chk("reset_rx_valid", {31'd0, u_if.rx_valid}, 32'd0);
    chk("reset_frame_err", {31'd0, u_if.frame_err}, 32'd0);
    chk("reset_rx_busy", {31'd0, u_if.rx_busy}, 32'd0);
    rst_n = 1'b1;
    idle_bits(2);

    // Single frame with latency check
    send_frame(8'h41, 1'b1, c_bit_ns, 1'b1, 0.0);
    idle_bits(2);

    // Back-to-back frames, no idle gap
    send_frame(8'h55, 1'b1, c_bit_ns, 1'b1, 0.0);
    send_frame(8'hAA, 1'b1, c_bit_ns, 1'b1, 0.0);
    idle_bits(2);

    // Short low glitch on an idle line
    u_if.uart_rxd = 1'b0;
    #200;
    u_if.uart_rxd = 1'b1;
    #100;
    chk("glitch_busy_high", {31'd0, u_if.rx_busy}, 32'd1);
    #1000;
    chk("glitch_busy_cleared", {31'd0, u_if.rx_busy}, 32'd0);
    send_frame(8'h3C, 1'b1, c_bit_ns, 1'b1, 0.0);
    idle_bits(2);

    // Bad stop bit followed by a long break
    send_frame(8'h0F, 1'b0, c_bit_ns, 1'b0, 20000.0);
    idle_bits(2);
    chk("busy_after_break", {31'd0, u_if.rx_busy}, 32'd0);
    send_frame(8'h7E, 1'b1, c_bit_ns, 1'b1, 0.0);
    idle_bits(2);

    // Reset late in bit 4 of 0xC3; the frame is abandoned afterwards
    u_if.uart_rxd = 1'b0;
    #(c_bit_ns);
    for (int i = 0; i < 4; i++) begin
      u_if.uart_rxd = (8'hC3 >> i) & 8'h01 ? 1'b1 : 1'b0;
      #(c_bit_ns);
    end
    u_if.uart_rxd = 1'b0;
    #1100;
    rst_n = 1'b0;
    #50;
    chk("midreset_rx_data", {24'd0, u_if.rx_data}, 32'd0);
    chk("midreset_rx_valid", {31'd0, u_if.rx_valid}, 32'd0);
    chk("midreset_frame_err", {31'd0, u_if.frame_err}, 32'd0);
    chk("midreset_rx_busy", {31'd0, u_if.rx_busy}, 32'd0);
    #50;
    rst_n = 1'b1;
    #130;
    u_if.uart_rxd = 1'b1;
    idle_bits(12);
    chk("post_reset_busy", {31'd0, u_if.rx_busy}, 32'd0);
    chk("post_reset_data", {24'd0, u_if.rx_data}, 32'd0);
    send_frame(8'h5A, 1'b1, c_bit_ns, 1'b1, 0.0);
    idle_bits(2);

    // Transmitter baud off by +2% and -2%
    foreach (q[i]) begin end
    for (int s = 0; s < 2; s++) begin
      send_frame(8'h00, 1'b1, (s == 0) ? c_bit_ns / 1.02 : c_bit_ns / 0.98, 1'b0, 0.0);
      idle_bits(1);
      send_frame(8'hFF, 1'b1, (s == 0) ? c_bit_ns / 1.02 : c_bit_ns / 0.98, 1'b0, 0.0);
      idle_bits(1);
      send_frame(8'hA5, 1'b1, (s == 0) ? c_bit_ns / 1.02 : c_bit_ns / 0.98, 1'b0, 0.0);
      idle_bits(2);
    end

    // Random bytes, occasional bad stop bit, random idle gaps
    for (int n = 0; n < 12; n++) begin
      logic [7:0] d;
      bit         stop_ok;
      d       = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 3) != 0);
      send_frame(d, stop_ok, c_bit_ns, 1'b1, 0.0);
      idle_bits(stop_ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3)));
    end

    idle_bits(3);
    chk("all_expected_seen", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
